dp_step_ctrl: RTL and testbench

Execution sequencer for the single-cycle processor datapath. Converts operator controls (debounced step button, run switch, rate select, PC breakpoint) into a one-cycle execute-enable pulse `dp_en`. The datapath's PC, register file and data memory use `dp_en` as their write/update enable on the system clock, in place of a button-derived clock. It also stops execution on a halt opcode and counts retired instructions for the VIO and display.

---
 rtl/dp_step_ctrl_if.sv | 27 ++
 rtl/dp_step_ctrl.sv | 131 +++++++++++++
 tb/tb_dp_step_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_step_ctrl_if.sv
// Operator-control and datapath-status bundle for dp_step_ctrl.
// master: the side that drives the controls (board/VIO/bench). slave: the sequencer.
interface dp_step_ctrl_if #(
    parameter int unsigned RATE_W = 3
);
    logic              step_pb;
    logic              run_sw;
    logic [RATE_W-1:0] rate_sel;
    logic              bp_en;
    logic [7:0]        bp_addr;
    logic [7:0]        pc;
    logic [3:0]        opcode;
    logic              dp_en;
    logic [1:0]        state;
    logic              halted;
    logic [15:0]       instr_cnt;

    modport master (
        output step_pb, run_sw, rate_sel, bp_en, bp_addr, pc, opcode,
        input  dp_en, state, halted, instr_cnt
    );

    modport slave (
        input  step_pb, run_sw, rate_sel, bp_en, bp_addr, pc, opcode,
        output dp_en, state, halted, instr_cnt
    );
endinterface

// File: rtl/dp_step_ctrl.sv
// Execution sequencer: turns step/run/breakpoint/halt controls into a one-cycle dp_en pulse.
// Define DP_STEP_CTRL_INSTR_CNT_EN to build the 16-bit retired-instruction counter.
module dp_step_ctrl #(
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter int unsigned RATE_W      = 3
) (
    input  logic           clk,
    input  logic           rst,
    dp_step_ctrl_if.slave  bus
);
    localparam int unsigned PS_W  = (1 << RATE_W) - 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        BRK  = 2'b10,
        HALT = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, sync3_q;
    logic            step_rise_q, step_rise_d;
    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic            run_arm_q, run_arm_d;
    logic            dp_en_q, dp_en_d;
    logic            halted_q, halted_d;

    logic [PS_W:0]   ps_one;
    logic [PS_W-1:0] ps_term;
    logic            tick;
    logic            bp_hit;
    logic            issue;

    // Prescaler terminal value and breakpoint compare
    always_comb begin
        ps_one  = (PS_W+1)'(1) << bus.rate_sel;
        ps_term = PS_W'(ps_one - (PS_W+1)'(1));
        tick    = (state_q == RUN) && !run_arm_q && (ps_cnt_q == ps_term);
        bp_hit  = bus.bp_en && (bus.pc == bus.bp_addr);
    end

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        step_rise_d = sync2_q & ~sync3_q;

        unique case (state_q)
            IDLE: begin
                if (bus.run_sw)       state_d = RUN;
                else if (step_rise_q) issue   = 1'b1;
            end
            RUN: begin
                if (!bus.run_sw) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (bp_hit) state_d = BRK;
                    else        issue   = 1'b1;
                end
            end
            BRK: begin
                if (step_rise_q) begin
                    issue   = 1'b1;
                    state_d = bus.run_sw ? RUN : IDLE;
                end else if (!bus.run_sw) begin
                    state_d = IDLE;
                end
            end
            HALT: ;
            default: state_d = IDLE;
        endcase

        // The halt instruction still retires; everything after it is blocked
        if (issue && (bus.opcode == HALT_OPCODE)) state_d = HALT;

        dp_en_d   = issue;
        halted_d  = (state_d == HALT);
        run_arm_d = (state_d == RUN) && (state_q != RUN);

        // The first RUN cycle only clears the prescaler, so the first tick lands P+1 after entry
        if ((state_q != RUN) || run_arm_q || tick) ps_cnt_d = '0;
        else                                       ps_cnt_d = ps_cnt_q + PS_W'(1);
    end

    // rst release is expected to be synchronised upstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            step_rise_q <= 1'b0;
            ps_cnt_q    <= '0;
            run_arm_q   <= 1'b0;
            dp_en_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.step_pb;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            step_rise_q <= step_rise_d;
            ps_cnt_q    <= ps_cnt_d;
            run_arm_q   <= run_arm_d;
            dp_en_q     <= dp_en_d;
            halted_q    <= halted_d;
        end
    end

    assign bus.dp_en  = dp_en_q;
    assign bus.state  = state_q;
    assign bus.halted = halted_q;

`ifdef DP_STEP_CTRL_INSTR_CNT_EN
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q + CNT_W'(dp_en_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instr_cnt_q <= '0;
        else      instr_cnt_q <= instr_cnt_d;
    end

    assign bus.instr_cnt = instr_cnt_q;
`else
    assign bus.instr_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_dp_step_ctrl.sv
// Directed bench for dp_step_ctrl: step, free-run rate, breakpoint, halt, run priority, reset, counter.
module tb_dp_step_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    dp_step_ctrl_if #(.RATE_W(3)) bus ();

    dp_step_ctrl #(.HALT_OPCODE(4'hF), .RATE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.step_pb  = 1'b0;
        bus.run_sw   = 1'b0;
        bus.rate_sel = 3'd0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = 8'd0;
        bus.pc       = 8'd0;
        bus.opcode   = 4'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.state); end
        checks++; if (bus.dp_en !== 1'b0) begin failures++; $display("FAIL reset_dp_en got=%b exp=0", bus.dp_en); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.instr_cnt !== 16'h0000) begin failures++; $display("FAIL reset_instr_cnt got=%h exp=0000", bus.instr_cnt); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_step();
        int   hits = 0;
        int   idx  = 0;
        logic st_bad = 1'b0;
        logic [15:0] exp_cnt;
`ifdef DP_STEP_CTRL_INSTR_CNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        bus.step_pb = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) begin
                hits++;
                if (idx == 0) idx = i;
            end
            if (bus.state !== 2'b00) st_bad = 1'b1;
        end
        bus.step_pb = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hits != 1) begin failures++; $display("FAIL step_pulse_count got=%0d exp=1", hits); end
        checks++; if (idx != 4) begin failures++; $display("FAIL step_latency got=%0d exp=4", idx); end
        checks++; if (st_bad !== 1'b0) begin failures++; $display("FAIL step_state_left_idle got=%b exp=0", st_bad); end
        checks++; if (bus.instr_cnt !== exp_cnt) begin failures++; $display("FAIL step_instr_cnt got=%0d exp=%0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_run_rate();
        logic [13:0] pat;
        logic [7:0]  pat0;
        bus.rate_sel = 3'd2;
        bus.run_sw   = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            pat[i] = bus.dp_en;
        end
        checks++; if (pat !== 14'h2220) begin failures++; $display("FAIL run_rate2_pattern got=%h exp=2220", pat); end
        checks++; if (bus.state !== 2'b01) begin failures++; $display("FAIL run_state got=%b exp=01", bus.state); end
        bus.rate_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat0[i] = bus.dp_en;
        end
        checks++; if (pat0 !== 8'hFF) begin failures++; $display("FAIL run_rate0_pattern got=%h exp=ff", pat0); end
        bus.run_sw = 1'b0;
        @(negedge clk);
        checks++; if (bus.dp_en !== 1'b0) begin failures++; $display("FAIL run_stop_dp_en got=%b exp=0", bus.dp_en); end
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL run_stop_state got=%b exp=00", bus.state); end
    endtask

    task automatic test_run_priority();
        int hits = 0;
        bus.rate_sel = 3'd2;
        bus.run_sw   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) hits++;
        end
        bus.run_sw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) hits++;
        end
        checks++; if (hits != 0) begin failures++; $display("FAIL prio_pulses got=%0d exp=0", hits); end
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL prio_state got=%b exp=00", bus.state); end
    endtask

    task automatic test_breakpoint();
        int         hits = 0;
        logic [1:0] st_at = 2'b00;
        logic [7:0] first_pc = 8'hFF;
        bus.rate_sel = 3'd1;
        bus.bp_en    = 1'b1;
        bus.bp_addr  = 8'h05;
        bus.pc       = 8'h00;
        bus.run_sw   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) begin hits++; bus.pc = bus.pc + 8'd1; end
        end
        checks++; if (hits != 5) begin failures++; $display("FAIL bp_pulses got=%0d exp=5", hits); end
        checks++; if (bus.state !== 2'b10) begin failures++; $display("FAIL bp_state got=%b exp=10", bus.state); end
        checks++; if (bus.pc !== 8'h05) begin failures++; $display("FAIL bp_pc got=%h exp=05", bus.pc); end

        hits = 0;
        bus.step_pb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) begin hits++; st_at = bus.state; bus.pc = bus.pc + 8'd1; end
        end
        bus.step_pb = 1'b0;
        checks++; if (hits != 1) begin failures++; $display("FAIL bp_step_pulses got=%0d exp=1", hits); end
        checks++; if (st_at !== 2'b01) begin failures++; $display("FAIL bp_step_state got=%b exp=01", st_at); end

        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) begin
                if (hits == 0) first_pc = bus.pc;
                hits++;
                bus.pc = bus.pc + 8'd1;
            end
        end
        checks++; if (hits != 3) begin failures++; $display("FAIL bp_resume_pulses got=%0d exp=3", hits); end
        checks++; if (first_pc !== 8'h06) begin failures++; $display("FAIL bp_resume_pc got=%h exp=06", first_pc); end
    endtask

    task automatic test_halt();
        logic       found = 1'b0;
        logic [1:0] st_at = 2'b00;
        logic       hlt_at = 1'b0;
        int         hits = 0;
        bus.opcode = 4'hF;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) begin found = 1'b1; st_at = bus.state; hlt_at = bus.halted; end
        end
        bus.opcode = 4'h0;
        checks++; if (found !== 1'b1) begin failures++; $display("FAIL halt_final_pulse got=%b exp=1 (timeout)", found); end
        checks++; if (st_at !== 2'b11) begin failures++; $display("FAIL halt_state got=%b exp=11", st_at); end
        checks++; if (hlt_at !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", hlt_at); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) hits++;
            if (i == 2)  bus.step_pb = 1'b1;
            if (i == 4)  bus.run_sw  = 1'b0;
            if (i == 8)  bus.step_pb = 1'b0;
            if (i == 10) bus.run_sw  = 1'b1;
        end
        checks++; if (hits != 0) begin failures++; $display("FAIL halt_no_pulses got=%0d exp=0", hits); end
        checks++; if (bus.state !== 2'b11) begin failures++; $display("FAIL halt_sticky got=%b exp=11", bus.state); end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL halt_reset_state got=%b exp=00", bus.state); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_reset_halted got=%b exp=0", bus.halted); end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        bus.rate_sel = 3'd0;
        bus.run_sw   = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bus.dp_en !== 1'b1) begin failures++; $display("FAIL midpulse_pre got=%b exp=1", bus.dp_en); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.dp_en !== 1'b0) begin failures++; $display("FAIL midpulse_drop got=%b exp=0", bus.dp_en); end
        checks++; if (bus.instr_cnt !== 16'h0000) begin failures++; $display("FAIL midpulse_instr_cnt got=%h exp=0000", bus.instr_cnt); end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        int   hits = 0;
        logic done = 1'b0;
`ifdef DP_STEP_CTRL_INSTR_CNT_EN
        bus.rate_sel = 3'd0;
        bus.run_sw   = 1'b1;
        for (int i = 0; i < 70000 && !done; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) begin
                hits++;
                if (hits == 65536) begin
                    checks++; if (bus.instr_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", bus.instr_cnt); end
                    bus.run_sw = 1'b0;
                    done = 1'b1;
                end
            end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_reached got=%0d pulses exp=65536 (timeout)", hits); end
        @(negedge clk);
        checks++; if (bus.instr_cnt !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h exp=0000", bus.instr_cnt); end
        checks++; if (bus.state !== 2'b00) begin failures++; $display("FAIL wrap_state got=%b exp=00", bus.state); end
`else
        bus.rate_sel = 3'd0;
        bus.run_sw   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.dp_en === 1'b1) hits++;
            if (bus.instr_cnt !== 16'h0000) done = 1'b1;
        end
        bus.run_sw = 1'b0;
        checks++; if (hits != 18) begin failures++; $display("FAIL nocnt_pulses got=%0d exp=18", hits); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL nocnt_nonzero got=%b exp=0", done); end
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_rate();
        test_run_priority();
        test_breakpoint();
        test_halt();
        test_reset_mid_pulse();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
